// File: rtl/sw_seq_pkg.sv
// Shared types and default sizing for the switch sequencer.
package sw_seq_pkg;

   localparam int unsigned TW_DEF    = 16;
   localparam int unsigned DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRE  = 2'd2
   } state_t;

endpackage

// File: rtl/sw_seq_fifo.sv
// Event-time FIFO: DEPTH entries of W bits, registered count and full/empty flags.
module sw_seq_fifo
   import sw_seq_pkg::*;
#(
   parameter int unsigned W     = TW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_full;
   logic          r_empty;

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (i_push && !i_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!i_push && i_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == CW'(0));
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/switch_sequencer.sv
// Timed switch sequencer: queued absolute toggle times are applied in arrival
// order against a saturating tick counter, one toggle per FIRE visit.
module switch_sequencer
   import sw_seq_pkg::*;
#(
   parameter int unsigned TW    = TW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter bit          INIT  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          ev_valid,
   output logic          ev_ready,
   input  logic [TW-1:0] ev_time,
   output logic          sw_on,
   output logic          busy,
   output logic          fire,
   output logic          late
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [TW-1:0] TMAX = '1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_tnow;
   logic [TW-1:0] w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_more;
   logic          r_sw_on;
   logic          r_fire;
   logic          r_late;
   logic          w_sw_nxt;
   logic          w_fire_nxt;
   logic          w_late_nxt;

   // Ready comes from the registered full flag only, so a pop never opens it early.
   assign w_push = ev_valid & ~w_full;
   assign w_more = (w_count > CW'(1)) | w_push;

   sw_seq_fifo #(
      .W     (TW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (ev_time),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tnow <= '0;
      end else if (en && (r_tnow != TMAX)) begin
         r_tnow <= r_tnow + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sw_nxt    = r_sw_on;
      w_fire_nxt  = 1'b0;
      w_late_nxt  = r_late;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (w_empty) begin
               w_state_nxt = IDLE;
            end else if (w_head <= r_tnow) begin
               w_state_nxt = FIRE;
               w_sw_nxt    = ~r_sw_on;
               w_fire_nxt  = 1'b1;
               if (w_head < r_tnow) begin
                  w_late_nxt = 1'b1;
               end
            end
         end
         FIRE: begin
            w_pop       = 1'b1;
            w_state_nxt = w_more ? ARMED : IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Toggle and pulse are registered on the edge that enters FIRE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sw_on <= INIT;
         r_fire  <= 1'b0;
         r_late  <= 1'b0;
      end else begin
         r_sw_on <= w_sw_nxt;
         r_fire  <= w_fire_nxt;
         r_late  <= w_late_nxt;
      end
   end

   assign ev_ready = ~w_full;
   assign busy     = ~w_empty;
   assign sw_on    = r_sw_on;
   assign fire     = r_fire;
   assign late     = r_late;

endmodule

// File: doc/switch_sequencer.md
SWITCH_SEQUENCER -- requirements
Module: switch_sequencer

Interface
REQ-001 The parameter list SHALL be: TW, default 16, width of time counter and event times in clock ticks.
REQ-002 The parameter list SHALL be: DEPTH, default 4, event queue depth (power of two, >=2).
REQ-003 The parameter list SHALL be: INIT, default 0, switch state after reset (0=off, 1=on).
REQ-004 The block SHALL have: clk  input  1  sole clock, all state on rising edge.
REQ-005 The block SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have: en  input  1  time counter advance enable.
REQ-007 The block SHALL have: ev_valid  input  1  event offer.
REQ-008 The block SHALL have: ev_ready  output  1  queue can accept (= not full).
REQ-009 The block SHALL have: ev_time  input  TW  absolute toggle time of offered event.
REQ-010 The block SHALL have: sw_on  output  1  switch control level driving the downstream switch/relay model.
REQ-011 The block SHALL have: busy  output  1  queue non-empty.
REQ-012 The block SHALL have: fire  output  1  one-cycle pulse on each toggle.
REQ-013 The block SHALL have: late  output  1  sticky flag, an event was applied after its time.

Function
REQ-014 Event accepted SHALL occur on a rising edge with ev_valid && ev_ready; accepted event enters FIFO tail.
REQ-015 Time counter tnow SHALL increment by 1 per cycle while en=1, hold while en=0, saturate at 2^TW-1 (no wrap).
REQ-016 The FSM SHALL have states IDLE (queue empty), ARMED (head pending), FIRE (toggle cycle).
REQ-017 The FSM SHALL take IDLE->ARMED on the cycle after the first accept into an empty queue.
REQ-018 The FSM SHALL take ARMED->FIRE when head ev_time <= tnow (unsigned compare).
REQ-019 In FIRE: sw_on SHALL invert, fire=1 for exactly that cycle, head popped; next state ARMED if queue still non-empty after pop, else IDLE.
REQ-020 Latency: event with ev_time=T SHALL toggle sw_on at the rising edge after the one where tnow becomes T (1-cycle compare latency).
REQ-021 If head ev_time < tnow on entry to compare, late SHALL be set to 1 and the event still fires; late clears only on rst.
REQ-022 At most one toggle SHALL occur per FIRE cycle; events with equal times fire on consecutive FIRE visits (minimum 2 cycles apart).
REQ-023 Full queue: ev_ready=0; simultaneous pop in FIRE SHALL NOT raise ev_ready combinationally (ready depends on registered count only).
REQ-024 Push and pop in same cycle SHALL leave count unchanged and preserve order.
REQ-025 Events pushed with non-monotonic times SHALL be served in FIFO order, not time order.
REQ-026 en=0 SHALL freeze tnow only; queued events with time <= frozen tnow still fire.

Reset
REQ-027 While rst=1, outputs SHALL be: sw_on=INIT, fire=0, late=0, busy=0, ev_ready=1, tnow=0, FIFO emptied, state IDLE, asynchronously.
REQ-028 Reset mid-FIRE SHALL discard the toggle and all queued events; no fire pulse after deassertion until a new event matures.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 A shared package sw_seq_pkg SHALL hold the state enum (IDLE, ARMED, FIRE) and the TW/DEPTH defaults.
REQ-031 The FIFO SHALL be one sub-module, sw_seq_fifo (DEPTH x TW, registered count, full/empty); FSM, counter, and compare stay in switch_sequencer.

Verification
REQ-032 Scenario: INIT=0, en=1, push times 5,10 -> sw_on rises after tnow=5 edge, falls after tnow=10 edge; two fire pulses; late=0.
REQ-033 Scenario: push DEPTH=4 events back-to-back with en=0 -> ev_ready=0 after 4th accept; 5th offer held, accepted after first fire.
REQ-034 Scenario: run to tnow=20, then push time 3 -> fires within 2 cycles, late=1 and remains 1.
REQ-035 Scenario: push times 8,8 -> two fire pulses 2 cycles apart, sw_on returns to INIT level.
REQ-036 Scenario: rst asserted in FIRE cycle with 2 events queued -> sw_on=INIT immediately, busy=0, no further fire.
REQ-037 Scenario: TW=4, en held 30 cycles -> tnow saturates at 15; event time 15 fires once.
